// File: rtl/dog_up_pkg.sv
// Shared constants and types for the DoG 2x nearest-neighbour upsampler.
package dog_up_pkg;

  localparam int unsigned PIX_W         = 8;
  localparam int unsigned DEF_IN_WIDTH  = 400;
  localparam int unsigned DEF_IN_HEIGHT = 300;

  typedef enum logic {
    FILL,
    REPLAY
  } src_state_t;

endpackage

// File: rtl/up_line_buffer.sv
// Single-port synchronous line buffer, one-cycle read latency.
module up_line_buffer
  import dog_up_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_IN_WIDTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Write when enabled; the addressed word is always read out registered.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dog_up_sampler.sv
// 2x nearest-neighbour upsampler: each FIFO row is captured into a line
// buffer while streamed out, then replayed once from the buffer; every
// pixel is emitted twice on the valid/ready output.
module dog_up_sampler
  import dog_up_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned IN_HEIGHT = DEF_IN_HEIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             rd_en_up,
  input  logic             fifo_valid,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout,
  output logic             valid_out,
  input  logic             ready,
  output logic             sof,
  output logic             eol
);

  localparam int unsigned CW  = $clog2(IN_WIDTH + 1);
  localparam int unsigned AW  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned RW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned OCW = $clog2(2 * IN_WIDTH);
  localparam int unsigned ORW = $clog2(2 * IN_HEIGHT);
  localparam logic [CW-1:0]  COL_END   = CW'(IN_WIDTH);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IN_HEIGHT - 1);
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(2 * IN_WIDTH - 1);
  localparam logic [ORW-1:0] OROW_LAST = ORW'(2 * IN_HEIGHT - 1);

  src_state_t state, state_d;
  logic [CW-1:0]    rd_col;
  logic [RW-1:0]    row;
  logic [AW-1:0]    wr_addr;
  logic             rd_pend;
  logic [PIX_W-1:0] pix, nxt, ram_q, ret_data;
  logic             pix_vld, nxt_vld, phase;
  logic [OCW-1:0]   out_col;
  logic [ORW-1:0]   out_row;
  logic             ret, accept, drain, pix_free, nxt_vld_d;
  logic             can_issue, fifo_rd, ram_rd, issue, row_inc;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;

  // Read issue, data return and pipeline occupancy.
  always_comb begin
    ret       = rd_pend && ((state == REPLAY) || fifo_valid);
    ret_data  = (state == FILL) ? din : ram_q;
    accept    = pix_vld && ready;
    drain     = accept && phase;
    pix_free  = !pix_vld || drain;
    nxt_vld_d = pix_free ? (nxt_vld && ret) : (nxt_vld || ret);
    can_issue = !rst && !rd_pend && (rd_col < COL_END) && !nxt_vld_d;
    fifo_rd   = can_issue && (state == FILL) && !fifo_empty;
    ram_rd    = can_issue && (state == REPLAY);
    issue     = fifo_rd || ram_rd;
    ram_we    = (state == FILL) && ret;
    ram_addr  = ram_we ? wr_addr : rd_col[AW-1:0];
  end

  // Next-state logic; a read returning this cycle no longer counts as
  // outstanding, so REPLAY can start reading right behind the last write.
  always_comb begin
    state_d = state;
    row_inc = 1'b0;
    case (state)
      FILL:   if (rd_col == COL_END && !(rd_pend && !ret)) state_d = REPLAY;
      REPLAY: if (rd_col == COL_END) begin
        state_d = FILL;
        row_inc = 1'b1;
      end
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_d;
  end

  // Counters, read tracking and the two-entry pixel pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_col  <= '0;
      row     <= '0;
      wr_addr <= '0;
      rd_pend <= 1'b0;
      pix     <= '0;
      nxt     <= '0;
      pix_vld <= 1'b0;
      nxt_vld <= 1'b0;
      phase   <= 1'b0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      rd_pend <= issue;
      if (fifo_rd) wr_addr <= rd_col[AW-1:0];
      if (state_d != state) rd_col <= '0;
      else if (issue)       rd_col <= rd_col + 1'b1;
      if (row_inc) row <= (row == ROW_LAST) ? '0 : row + 1'b1;

      if (pix_free) begin
        if (nxt_vld) begin
          pix     <= nxt;
          pix_vld <= 1'b1;
          if (ret) nxt <= ret_data;
          nxt_vld <= ret;
        end else if (ret) begin
          pix     <= ret_data;
          pix_vld <= 1'b1;
        end else begin
          pix_vld <= 1'b0;
        end
      end else if (ret) begin
        nxt     <= ret_data;
        nxt_vld <= 1'b1;
      end

      if (accept) begin
        phase <= ~phase;
        if (out_col == OCOL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == OROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  up_line_buffer #(
    .DEPTH(IN_WIDTH),
    .AW   (AW)
  ) u_line_buffer (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(din),
    .rdata(ram_q)
  );

  assign rd_en_up  = fifo_rd;
  assign dout      = pix;
  assign valid_out = pix_vld;
  assign sof       = pix_vld && (out_col == '0) && (out_row == '0);
  assign eol       = pix_vld && (out_col == OCOL_LAST);

endmodule

// File: tb/tb_dog_up_sampler.sv
// Directed bench for dog_up_sampler with a 4x2 frame and a simple FIFO model.
module tb_dog_up_sampler;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic       fifo_empty, rd_en_up, valid_out, sof, eol;
  logic       fifo_valid = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dog_up_sampler #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .rd_en_up  (rd_en_up),
    .fifo_valid(fifo_valid),
    .din       (din),
    .dout      (dout),
    .valid_out (valid_out),
    .ready     (ready),
    .sof       (sof),
    .eol       (eol)
  );

  // FIFO model: registered read, flushed by the shared reset.
  logic [7:0] fmem [256];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (rst) begin
      fifo_valid <= 1'b0;
      rd_cnt     <= wr_cnt;
    end else if (rd_en_up && !fifo_empty) begin
      fifo_valid <= 1'b1;
      din        <= fmem[rd_cnt[7:0]];
      rd_cnt     <= rd_cnt + 1;
    end else begin
      fifo_valid <= 1'b0;
    end
  end

  // Per-cycle and per-accept capture.
  logic       cyc_v [512], cyc_r [512], cyc_rd [512], cyc_sof [512], cyc_eol [512];
  logic [7:0] cyc_d [512];
  logic       acc_sof [512], acc_eol [512];
  logic [7:0] acc_d [512];
  int ncyc = 0;
  int nacc = 0;

  task automatic push(input logic [7:0] v);
    fmem[wr_cnt[7:0]] = v;
    wr_cnt++;
  endtask

  task automatic step(input logic r);
    ready = r;
    #1;
    if (ncyc < 512) begin
      cyc_v[ncyc] = valid_out; cyc_r[ncyc] = r; cyc_rd[ncyc] = rd_en_up;
      cyc_d[ncyc] = dout; cyc_sof[ncyc] = sof; cyc_eol[ncyc] = eol;
      ncyc++;
    end
    if (valid_out && ready && !rst && nacc < 512) begin
      acc_d[nacc] = dout; acc_sof[nacc] = sof; acc_eol[nacc] = eol;
      nacc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ncyc = 0;
    nacc = 0;
  endtask

  function automatic logic [7:0] exp_val(input int k);
    int f, j;
    f = k / 32;
    j = k % 32;
    return 8'(f * 8 + (j / 16) * 4 + (j % 8) / 2 + 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push(8'h11);
    #1;
    checks++; if (rd_en_up !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en_up); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h want 0", dout); end
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL reset_sof got %b want 0", sof); end
    checks++; if (eol !== 1'b0) begin errors++; $display("FAIL reset_eol got %b want 0", eol); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int gaps;
    do_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    while (nacc < 32 && ncyc < 100) step(1'b1);
    repeat (4) step(1'b1);
    checks++; if (cyc_rd[0] !== 1'b1) begin errors++; $display("FAIL first_rd got %b want 1", cyc_rd[0]); end
    checks++; if (cyc_v[1] !== 1'b0) begin errors++; $display("FAIL lat_t1_valid got %b want 0", cyc_v[1]); end
    checks++; if (cyc_v[2] !== 1'b1 || cyc_d[2] !== 8'd1) begin
      errors++; $display("FAIL lat_t2 got valid=%b dout=%0h want valid=1 dout=1", cyc_v[2], cyc_d[2]);
    end
    gaps = 0;
    for (int c = 2; c < 34; c++) if (cyc_v[c] !== 1'b1) gaps++;
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d want 0", gaps); end
    checks++; if (nacc != 32) begin errors++; $display("FAIL stream_count got %0d want 32", nacc); end
    for (int k = 0; k < 32 && k < nacc; k++) begin
      checks++; if (acc_d[k] !== exp_val(k)) begin errors++; $display("FAIL stream_pix k=%0d got %0h want %0h", k, acc_d[k], exp_val(k)); end
      checks++; if (acc_sof[k] !== (k == 0)) begin errors++; $display("FAIL stream_sof k=%0d got %b want %b", k, acc_sof[k], (k == 0)); end
      checks++; if (acc_eol[k] !== (k % 8 == 7)) begin errors++; $display("FAIL stream_eol k=%0d got %b want %b", k, acc_eol[k], (k % 8 == 7)); end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int i, bad;
    pat = 6'b101001;
    i = 0;
    do_reset();
    for (int v = 1; v <= 8; v++) push(8'(v));
    while (nacc < 32 && ncyc < 300) begin
      step(pat[i % 6]);
      i++;
    end
    bad = 0;
    for (int c = 1; c < ncyc; c++)
      if (cyc_v[c-1] && !cyc_r[c-1])
        if (cyc_v[c] !== 1'b1 || cyc_d[c] !== cyc_d[c-1] || cyc_sof[c] !== cyc_sof[c-1] || cyc_eol[c] !== cyc_eol[c-1]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable got %0d unstable stalls want 0", bad); end
    checks++; if (nacc != 32) begin errors++; $display("FAIL bp_count got %0d want 32", nacc); end
    for (int k = 0; k < 32 && k < nacc; k++) begin
      checks++; if (acc_d[k] !== exp_val(k)) begin errors++; $display("FAIL bp_pix k=%0d got %0h want %0h", k, acc_d[k], exp_val(k)); end
    end
  endtask

  task automatic test_fifo_empty();
    int bad;
    logic [7:0] e1 [4];
    logic [7:0] e2 [5];
    e1 = '{8'd1, 8'd1, 8'd2, 8'd2};
    e2 = '{8'd3, 8'd3, 8'd4, 8'd4, 8'd1};
    do_reset();
    push(8'd1);
    push(8'd2);
    repeat (16) step(1'b1);
    bad = 0;
    for (int c = 3; c < 16; c++) if (cyc_rd[c] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_rd_en got %0d reads want 0", bad); end
    checks++; if (nacc != 4) begin errors++; $display("FAIL empty_count got %0d want 4", nacc); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (acc_d[k] !== e1[k]) begin errors++; $display("FAIL empty_pix k=%0d got %0h want %0h", k, acc_d[k], e1[k]); end
    end
    checks++; if (cyc_v[6] !== 1'b0 || cyc_v[15] !== 1'b0) begin
      errors++; $display("FAIL empty_valid got %b/%b want 0/0", cyc_v[6], cyc_v[15]);
    end
    push(8'd3);
    push(8'd4);
    repeat (12) step(1'b1);
    checks++; if (nacc != 14) begin errors++; $display("FAIL resume_count got %0d want 14", nacc); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (acc_d[k+4] !== e2[k]) begin errors++; $display("FAIL resume_pix k=%0d got %0h want %0h", k + 4, acc_d[k+4], e2[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    for (int v = 1; v <= 8; v++) push(8'(v));
    while (nacc < 5 && ncyc < 50) step(1'b1);
    checks++; if (nacc != 5) begin errors++; $display("FAIL mid_pre_count got %0d want 5", nacc); end
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    step(1'b1);
    c = ncyc - 1;
    checks++; if ({cyc_rd[c], cyc_v[c], cyc_sof[c], cyc_eol[c]} !== 4'b0000 || cyc_d[c] !== 8'h00) begin
      errors++; $display("FAIL mid_outputs got rd=%b v=%b sof=%b eol=%b dout=%0h want all 0",
                         cyc_rd[c], cyc_v[c], cyc_sof[c], cyc_eol[c], cyc_d[c]);
    end
    checks++; if (dut.out_col !== '0) begin errors++; $display("FAIL mid_out_col got %0d want 0", dut.out_col); end
    nacc = 0;
    push(8'h5A);
    for (int n = 0; n < 10 && nacc < 1; n++) step(1'b1);
    checks++; if (nacc != 1) begin errors++; $display("FAIL mid_post_count got %0d want 1", nacc); end
    checks++; if (acc_d[0] !== 8'h5A || acc_sof[0] !== 1'b1 || acc_eol[0] !== 1'b0) begin
      errors++; $display("FAIL mid_first got dout=%0h sof=%b eol=%b want 5a/1/0", acc_d[0], acc_sof[0], acc_eol[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int v = 1; v <= 16; v++) push(8'(v));
    while (nacc < 64 && ncyc < 200) step(1'b1);
    checks++; if (nacc != 64) begin errors++; $display("FAIL b2b_count got %0d want 64", nacc); end
    for (int k = 0; k < 64 && k < nacc; k++) begin
      checks++; if (acc_d[k] !== exp_val(k)) begin errors++; $display("FAIL b2b_pix k=%0d got %0h want %0h", k, acc_d[k], exp_val(k)); end
      checks++; if (acc_sof[k] !== (k % 32 == 0)) begin errors++; $display("FAIL b2b_sof k=%0d got %b want %b", k, acc_sof[k], (k % 32 == 0)); end
      checks++; if (acc_eol[k] !== (k % 8 == 7)) begin errors++; $display("FAIL b2b_eol k=%0d got %b want %b", k, acc_eol[k], (k % 8 == 7)); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_fifo_empty();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dog_up_sampler.md
# dog_up_sampler

Reads 8-bit difference-of-Gaussian pixels from the DoG output FIFO and produces a 2x nearest-neighbour upsampled stream. Each input pixel is emitted twice horizontally, and each input row is emitted twice vertically. The block sits directly downstream of the Gaussian wrapper's FIFO read port, as the reader of that interface, and feeds the image buffer writer through a valid/ready stream with frame and line markers.

## Interface
- IN_WIDTH, 400: input pixels per row; output row is 2*IN_WIDTH.
- IN_HEIGHT, 300: input rows per frame; output frame is 2*IN_HEIGHT rows.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  DoG FIFO empty flag.
- rd_en_up  out  1  FIFO read request; data returns one cycle later.
- fifo_valid  in  1  FIFO read data valid (cycle after rd_en_up).
- din  in  8  FIFO read data.
- dout  out  8  upsampled pixel.
- valid_out  out  1  dout valid.
- ready  in  1  downstream accepts dout when valid_out & ready.
- sof  out  1  qualifies first output pixel of a frame.
- eol  out  1  qualifies last output pixel of each output row.

## Operation
- Source FSM has two states:
  - FILL: read IN_WIDTH pixels from the FIFO and write each into the line buffer at column rd_col.
  - REPLAY: read the same IN_WIDTH pixels back from the line buffer.
- FSM transitions:
  - FILL->REPLAY when rd_col==IN_WIDTH and no FIFO read is outstanding.
  - REPLAY->FILL when rd_col==IN_WIDTH; row counter increments at this point.
  - At row==IN_HEIGHT-1 the row counter wraps to 0.
  - rd_col clears on every transition.
- Pixel pipeline is two entries: stage register (nxt) and output register (pix).
  - Returning data (fifo_valid in FILL, or RAM read data in REPLAY) loads pix directly if pix is empty or being drained, else loads nxt.
- Read issue rules:
  - rd_en_up = FILL & !fifo_empty & rd_col<IN_WIDTH & no read outstanding & nxt will be free.
  - REPLAY issues line-buffer reads under the same occupancy rule.
- Output side:
  - pix is emitted twice (phase 0, phase 1).
  - Phase advances only on valid_out & ready.
  - After phase-1 accept, pix frees.
- Output counters: out_col (0..2*IN_WIDTH-1) and out_row (0..2*IN_HEIGHT-1).
  - sof = valid_out & out_col==0 & out_row==0.
  - eol = valid_out & out_col==2*IN_WIDTH-1.
- Stall: while valid_out & !ready, dout, sof and eol are held stable.
- A fifo_valid with no outstanding read is ignored.
- FIFO empty mid-row: rd_en_up deasserts; valid_out drops once pix drains; output resumes with no loss or duplication.
- Line buffer is single-port. No read and write ever occur in the same cycle, because FILL only writes and REPLAY only reads.
- Arithmetic: all counters are unsigned and sized with $clog2 of their bound. Pixel data passes unchanged; it is already offset-binary, with 128 representing zero.

## Timing
- Reset values: rd_en_up=0, valid_out=0, dout=0, sof=0, eol=0. State=FILL; all counters, phase and occupancy flags are 0.
- First rd_en_up may assert in the first cycle after rst deasserts.
- Latency:
  - rd_en_up in cycle t -> fifo_valid in t+1 -> valid_out in t+2.
  - In REPLAY, a RAM read issued in cycle t -> valid_out in t+2.
- Sustained rate: one output per cycle while ready=1 and the FIFO is non-empty. The FILL->REPLAY and REPLAY->FILL boundaries insert no bubbles.
- Reset mid-row: pipeline, counters and FSM clear in the same cycle.
  - The next emitted pixel carries sof.
  - The FIFO is reset by the same shared rst.

## Structure
- Package dog_up_pkg holds PIX_W=8, default IN_WIDTH and IN_HEIGHT, and the src_state_t enum {FILL, REPLAY}.
- Sub-module up_line_buffer: single-port synchronous RAM, IN_WIDTH x 8, one-cycle read latency, write-enable and address inputs.

## Test plan
- IN_WIDTH=4, IN_HEIGHT=2, FIFO preloaded 1..8, ready=1:
  - Output is 1,1,2,2,3,3,4,4 twice, then 5,5,...,8,8 twice; 32 pixels total.
  - sof on pixel 0; eol on pixels 7, 15, 23, 31.
- Latency: rd_en_up asserted at cycle t -> valid_out at t+2 with dout=1. Then one pixel per cycle with no gaps across row and state boundaries.
- Backpressure: ready pattern 1,0,0,1,0,1... -> dout stable during every stall; accepted sequence identical to the first scenario.
- FIFO empty for 10 cycles after 2 reads:
  - rd_en_up stays 0 while empty.
  - valid_out low after 1,1,2,2.
  - Output resumes 3,3 with no loss or duplication.
- rst pulsed after 5 outputs:
  - All outputs are 0 in the following cycle.
  - The next FIFO value emerges with sof=1 and out_col=0.
- Two back-to-back frames (16 FIFO values): sof on output 0 and output 32 only; row counter wraps correctly.
